// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the 7-segment scan driver.
//   scan_state_e : scan FSM states (OFF / BLANK / SHOW)
//   SEG_TABLE    : active-high segment patterns for hex 0..F (bit0=a .. bit6=g)
//   SEG_A..SEG_G, SEG_DP : bit positions inside the 8-bit segment bus
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_e;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Entry [n] is the pattern for hex digit n; listed F down to 0.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational hex nibble to active-high 7-segment pattern.
//   nib : hex value 0..F
//   seg : segments a..g (bit0=a), 1 = lit
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed 7-segment display driver.
//   clk, rst_n   : clock / async active-low reset
//   en           : display enable, 0 blanks everything and restarts the scan
//   load         : capture digits_i / dp_i into the shadow register
//   digits_i     : one hex nibble per digit, digit 0 in [3:0]
//   dp_i         : decimal point per digit
//   seg_o        : segments a..g, dp in bit7 (polarity per ACTIVE_LOW_SEG)
//   an_o         : one-hot digit select (polarity per ACTIVE_LOW_AN)
//   digit_idx_o  : index of the digit currently driven
// Optional: define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter bit ACTIVE_LOW_SEG = 1'b1,
  parameter bit ACTIVE_LOW_AN  = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          load,
  input  logic [4*NUM_DIGITS-1:0]       digits_i,
  input  logic [NUM_DIGITS-1:0]         dp_i,
  output logic [7:0]                    seg_o,
  output logic [NUM_DIGITS-1:0]         an_o,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx_o
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [7:0]            SEG_OFF = ACTIVE_LOW_SEG ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = ACTIVE_LOW_AN ? '1 : '0;

  logic [NUM_DIGITS-1:0][3:0] shadow;
  logic [NUM_DIGITS-1:0]      shadow_dp;
  scan_state_e                state;
  logic [IW-1:0]              idx;
  logic [PW-1:0]              presc;

  logic [3:0]            cur_nib;
  logic [6:0]            cur_seg;
  logic [7:0]            seg_act;
  logic [NUM_DIGITS-1:0] an_act;

  // Shadow register: the scan only ever reads this copy, so a partial
  // update on digits_i never shows up on the pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow    <= '0;
      shadow_dp <= '0;
    end else if (load) begin
      shadow    <= digits_i;
      shadow_dp <= dp_i;
    end
  end

  assign cur_nib = shadow[idx];

  seg7_hex_decode u_dec (
    .nib (cur_nib),
    .seg (cur_seg)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // lz[i]: digit i and everything above it are zero and dp[i] is off.
  // Digit 0 never blanks, so a zero value still shows a single "0".
  logic [NUM_DIGITS-1:0] lz;
  logic                  hi_zero;
  always_comb begin
    lz      = '0;
    hi_zero = 1'b1;
    for (int i = NUM_DIGITS-1; i >= 1; i--) begin
      hi_zero = hi_zero & (shadow[i] == 4'h0);
      lz[i]   = hi_zero & ~shadow_dp[i];
    end
  end

  always_comb begin
    seg_act                = '0;
    seg_act[SEG_G:SEG_A]   = cur_seg;
    seg_act[SEG_DP]        = shadow_dp[idx];
    if (lz[idx]) seg_act   = '0;
  end
`else
  always_comb begin
    seg_act              = '0;
    seg_act[SEG_G:SEG_A] = cur_seg;
    seg_act[SEG_DP]      = shadow_dp[idx];
  end
`endif

  assign an_act = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;

  // Scan FSM with registered pins. The pins reflect the state held before
  // the edge, except that en=0 forces them inactive on the very next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_OFF;
      idx         <= '0;
      presc       <= '0;
      seg_o       <= SEG_OFF;
      an_o        <= AN_OFF;
      digit_idx_o <= '0;
    end else if (!en) begin
      state       <= ST_OFF;
      idx         <= '0;
      presc       <= '0;
      seg_o       <= SEG_OFF;
      an_o        <= AN_OFF;
      digit_idx_o <= '0;
    end else begin
      case (state)
        ST_OFF: begin
          state       <= ST_BLANK;
          seg_o       <= SEG_OFF;
          an_o        <= AN_OFF;
          digit_idx_o <= '0;
        end
        ST_BLANK: begin
          // Dead-time between digits; digit_idx_o keeps the last shown digit.
          state <= ST_SHOW;
          seg_o <= SEG_OFF;
          an_o  <= AN_OFF;
        end
        ST_SHOW: begin
          seg_o       <= seg_act ^ SEG_OFF;
          an_o        <= an_act ^ AN_OFF;
          digit_idx_o <= idx;
          if (presc == PW'(SCAN_DIV-1)) begin
            presc <= '0;
            idx   <= (idx == IW'(NUM_DIGITS-1)) ? '0 : idx + 1'b1;
            state <= ST_BLANK;
          end else begin
            presc <= presc + 1'b1;
          end
        end
        default: begin
          state       <= ST_OFF;
          seg_o       <= SEG_OFF;
          an_o        <= AN_OFF;
          digit_idx_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver (NUM_DIGITS=4, SCAN_DIV=4, active-low pins).
// A reference model steps through the scan as a position within one
// NUM_DIGITS*(SCAN_DIV+1) period and queues the expected pins each edge;
// a monitor on the falling edge pops and compares.
module tb_seg7_scan_driver;

  localparam int ND  = 4;
  localparam int SD  = 4;
  localparam int PER = ND * (SD + 1);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_i = '0;
  logic [3:0]  dp_i = '0;
  logic [7:0]  seg_o;
  logic [3:0]  an_o;
  logic [1:0]  digit_idx_o;

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] an;
    logic [1:0] idx;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  logic [7:0] tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                           8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  seg7_scan_driver #(
    .NUM_DIGITS     (ND),
    .SCAN_DIV       (SD),
    .ACTIVE_LOW_SEG (1'b1),
    .ACTIVE_LOW_AN  (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .load        (load),
    .digits_i    (digits_i),
    .dp_i        (dp_i),
    .seg_o       (seg_o),
    .an_o        (an_o),
    .digit_idx_o (digit_idx_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit          m_on;
  int          m_pos;
  logic [15:0] m_sh;
  logic [3:0]  m_dp;
  logic [1:0]  m_didx;

  function automatic logic [7:0] m_seg(input int d);
    logic [7:0]  s;
    logic [6:0]  pat;
    logic [15:0] hi;
    pat = tab[m_sh[4*d +: 4]][6:0];
    s   = {m_dp[d], pat};
    hi  = m_sh >> (4*d);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (d != 0 && hi == 16'h0 && !m_dp[d]) s = 8'h00;
`endif
    return ~s;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    int   d;
    if (!rst_n) begin
      m_on = 0; m_pos = 0; m_sh = '0; m_dp = '0; m_didx = '0;
      q.push_back(exp_t'{8'hFF, 4'hF, 2'd0});
    end else begin
      if (!en || !m_on) begin
        m_didx = '0;
        e = exp_t'{8'hFF, 4'hF, 2'd0};
      end else if (m_pos % (SD + 1) == 0) begin
        e = exp_t'{8'hFF, 4'hF, m_didx};
      end else begin
        d = m_pos / (SD + 1);
        m_didx = 2'(d);
        e = exp_t'{m_seg(d), ~(4'b0001 << d), 2'(d)};
      end
      q.push_back(e);
      if (load) begin m_sh = digits_i; m_dp = dp_i; end
      if (!en)        m_on = 0;
      else if (!m_on) begin m_on = 1; m_pos = 0; end
      else            m_pos = (m_pos + 1) % PER;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_chk++;
      if ({seg_o, an_o, digit_idx_o} === e) n_pass++;
      else $display("FAIL pins @%0t: got seg=%h an=%h idx=%0d, want seg=%h an=%h idx=%0d",
                    $time, seg_o, an_o, digit_idx_o, e.seg, e.an, e.idx);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit e, input bit l, input logic [15:0] d,
                       input logic [3:0] p, input int n);
    repeat (n) begin
      @(negedge clk); #2;
      en = e; load = l; digits_i = d; dp_i = p;
    end
  endtask

  task automatic wait_an(input logic [3:0] want);
    bit found;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (an_o == want) found = 1;
    end
    if (!found) begin
      n_chk++;
      $display("FAIL wait_an: an_o=%h never reached %h", an_o, want);
    end
  endtask

  initial begin
    // reset and initial load of 1A3F with dp on digit 1
    drive(0, 0, 16'h0, 4'h0, 3);
    rst_n = 1'b1;
    drive(0, 1, 16'h1A3F, 4'b0010, 1);
    drive(1, 0, 16'h1A3F, 4'b0010, 45);

    // en dropped while digit 2 is lit, then re-enabled
    wait_an(4'b1011);
    #2;
    drive(0, 0, 16'h0, 4'h0, 3);
    drive(1, 0, 16'h0, 4'h0, 12);

    // load zeros while digit 0 is lit
    wait_an(4'b1110);
    #2;
    en = 1; load = 1; digits_i = 16'h0000; dp_i = 4'h0;
    drive(1, 0, 16'h0, 4'h0, 24);

    // load held high with changing data while disabled
    for (int i = 0; i < 6; i++)
      drive(0, 1, 16'($urandom), 4'($urandom), 1);
    drive(1, 0, 16'h0, 4'h0, 25);

    // leading-zero pattern 0050
    drive(1, 1, 16'h0050, 4'h0, 1);
    drive(1, 0, 16'h0, 4'h0, 24);

    // asynchronous reset while a digit is lit
    wait_an(4'b1101);
    #3;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (seg_o === 8'hFF && an_o === 4'hF && digit_idx_o === 2'd0) n_pass++;
    else $display("FAIL async_reset: got seg=%h an=%h idx=%0d, want seg=ff an=f idx=0",
                  seg_o, an_o, digit_idx_o);
    drive(0, 0, 16'h0, 4'h0, 2);
    rst_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 500; i++)
      drive(($urandom_range(0, 99) < 96), ($urandom_range(0, 9) == 0),
            16'($urandom), 4'($urandom), 1);

    drive(1, 0, 16'h0, 4'h0, 3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
